ws2812b_autocal_ctrl: RTL
=========================

Name: ws2812b_autocal_ctrl

Overview:
Self-calibrating configurator for the WS2812B pulse decoder and idle detector. On request it measures live high-pulse widths and bit periods on the synchronized data line. It computes the decoder's 0/1 discrimination threshold and the idle (frame-reset) tick count, then commits both as a new configuration. It sits beside the peripheral's register file and drives the decoder's `threshold_cycles` and the idle detector's `idle_threshold_ticks` in place of manual prescaler writes.

Parameters:
- CNT_W, 16, width of all cycle counters and config outputs.
- SAMPLE_BITS, 16, falling edges captured per calibration; must be ≥2.
- TIMEOUT_CYC, 8192, maximum cycles without an edge before aborting with an error.
- MIN_SPREAD, 8, minimum (max_high − min_high) for a valid result.
- IDLE_MULT, 48, idle_ticks = max_period × IDLE_MULT.
- DEF_THRESH, 38, reset value of threshold_cycles.
- DEF_IDLE, 3840, reset value of idle_ticks.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- din  in  1  data line, already synchronized
- start  in  1  one-cycle calibration request
- abort  in  1  one-cycle cancel
- threshold_cycles  out  CNT_W  committed decoder threshold
- idle_ticks  out  CNT_W  committed idle count
- cfg_valid  out  1  one-cycle pulse when outputs update
- busy  out  1  calibration in progress
- done  out  1  sticky success flag
- err  out  1  sticky failure flag
- err_code  out  2  0 none, 1 timeout, 2 insufficient spread
- min_high  out  CNT_W  last measured minimum high width
- max_high  out  CNT_W  last measured maximum high width

Behaviour:
- Reset values:
  - threshold_cycles = DEF_THRESH, idle_ticks = DEF_IDLE.
  - All flags, err_code, min_high, max_high = 0. State = IDLE.
- Edge detect uses one register din_q.
  - rise = din & ~din_q.
  - fall = ~din & din_q.
- High width = number of cycles din is sampled high, counted from the rise cycle (=1) through the cycle before the fall.
- Period = cycles between consecutive rises.
- All counters saturate at 2^CNT_W − 1.
- States:
  - IDLE: busy=0. On start: clear done, err, err_code; min_acc=all-ones, max_acc=0, max_per=0, bit_cnt=0; go to WAIT_LOW.
  - WAIT_LOW: wait for din=0, then go to WAIT_RISE. Calibration never starts mid-pulse.
  - WAIT_RISE: on rise, go to MEAS_HIGH.
  - MEAS_HIGH: on fall, update min_acc/max_acc with the high width and increment bit_cnt. If bit_cnt reaches SAMPLE_BITS go to COMPUTE, else go to MEAS_LOW.
  - MEAS_LOW: on rise, update max_per with the period and go to MEAS_HIGH. Only SAMPLE_BITS−1 periods are therefore recorded.
  - COMPUTE (1 cycle):
    - spread = max_acc − min_acc.
    - If spread < MIN_SPREAD: err=1, err_code=2, go to IDLE with no commit.
    - Otherwise: thr = (min_acc + max_acc) >> 1, computed at CNT_W+1 bits. idl = max_per × IDLE_MULT, saturated to CNT_W.
  - COMMIT (1 cycle): threshold_cycles←thr, idle_ticks←idl, cfg_valid=1, done=1; go to IDLE.
- busy = 1 in every state except IDLE.
- min_high and max_high are updated in COMPUTE regardless of outcome.
- Timeout: a counter clears on each edge and in IDLE.
  - Reaching TIMEOUT_CYC in any waiting or measuring state gives err=1, err_code=1, return to IDLE, no commit.
  - Example: a frame ends before SAMPLE_BITS edges.
- abort in any busy state returns to IDLE next cycle. There is no commit and done/err are unchanged. abort wins over a same-cycle start.
- start while busy is ignored.
- Latency: cfg_valid asserts 2 cycles after the cycle the final fall is seen.
- Outputs hold their last committed values until the next successful calibration or reset.
- Reset mid-calibration restores the defaults immediately.

Optional Feature:
- Macro: WS2812B_AUTOCAL_GLITCH_FILTER_EN.
- Defined: a high pulse shorter than 4 cycles is discarded entirely. It does not update min/max or bit_cnt, and its rise does not end the period. The state returns to MEAS_LOW, or WAIT_RISE if it was the first pulse.
- Undefined: every high pulse counts.

Decomposition:
- Package ws2812b_autocal_pkg holds:
  - the state enum (IDLE, WAIT_LOW, WAIT_RISE, MEAS_HIGH, MEAS_LOW, COMPUTE, COMMIT);
  - error-code constants ERR_NONE=0, ERR_TIMEOUT=1, ERR_SPREAD=2;
  - the glitch width constant GLITCH_CYC=4.
- One sub-module, ws2812b_edge_timer: din_q register, rise/fall outputs, saturating high-width and period counters.

Test Plan:
- Reset → threshold_cycles=38, idle_ticks=3840, busy=0, done=0, err=0.
- start, then 16 alternating bits (0: high 25/low 55, 1: high 51/low 29) → min_high=25, max_high=51, threshold_cycles=38, idle_ticks=3840, one cfg_valid pulse, done=1.
- start, then 16 "0" bits only (high 25/low 55) → spread 0, err=1, err_code=2, outputs still 38/3840, no cfg_valid.
- start with din held low for 8192 cycles → err=1, err_code=1, busy=0.
- start, 5 bits, then abort → busy=0 next cycle, done=0, err=0, no cfg_valid. A start during calibration has no effect.
- With WS2812B_AUTOCAL_GLITCH_FILTER_EN defined: a 2-cycle spike inserted between valid bits → same result as the clean stream (38/3840). Without the macro: min_high=2, threshold_cycles=26.

Source files
------------

// File: rtl/ws2812b_autocal_pkg.sv
// ws2812b_autocal_pkg
// Shared types and constants for the WS2812B auto-calibration controller:
//   state_t      - calibration FSM states
//   ERR_*        - err_code values reported by the controller
//   GLITCH_CYC   - high pulses shorter than this are treated as spikes
//                  when WS2812B_AUTOCAL_GLITCH_FILTER_EN is defined
package ws2812b_autocal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW,
        COMPUTE,
        COMMIT
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_SPREAD  = 2'd2;

    localparam int GLITCH_CYC = 4;

endpackage

// File: rtl/ws2812b_edge_timer.sv
// ws2812b_edge_timer
// Edge detector and pulse timers for the synchronized WS2812B data line.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   din         - synchronized data line
//   rise, fall  - single-cycle edge strobes (combinational from din/din_q)
//   high_width  - cycles din was high in the pulse now ending; valid on fall
//   period      - cycles since the previous rise; valid on rise
// Both counters saturate at all-ones.
module ws2812b_edge_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] high_width,
    output logic [CNT_W-1:0] period
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             din_q;
    logic [CNT_W-1:0] high_cnt_reg;
    logic [CNT_W-1:0] per_cnt_reg;

    assign rise       = din & ~din_q;
    assign fall       = ~din & din_q;
    assign high_width = high_cnt_reg;
    assign period     = per_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            din_q        <= 1'b0;
            high_cnt_reg <= '0;
            per_cnt_reg  <= '0;
        end else begin
            din_q <= din;

            // The rise cycle itself counts as the first high cycle, so by the
            // fall cycle the register holds exactly the number of high samples.
            if (rise) begin
                high_cnt_reg <= ONE;
            end else if (din && (high_cnt_reg != '1)) begin
                high_cnt_reg <= high_cnt_reg + ONE;
            end

            if (rise) begin
                per_cnt_reg <= ONE;
            end else if (per_cnt_reg != '1) begin
                per_cnt_reg <= per_cnt_reg + ONE;
            end
        end
    end

endmodule

// File: rtl/ws2812b_autocal_ctrl.sv
// ws2812b_autocal_ctrl
// Self-calibrating configurator for the WS2812B decoder and idle detector.
// On start it measures SAMPLE_BITS high pulses and the periods between them,
// then commits threshold_cycles = (min_high + max_high) / 2 and
// idle_ticks = max_period * IDLE_MULT (saturated).
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   din               - synchronized data line
//   start, abort      - one-cycle calibration request / cancel
//   threshold_cycles  - committed decoder threshold
//   idle_ticks        - committed idle (frame-reset) count
//   cfg_valid         - one-cycle pulse when the two outputs above update
//   busy              - calibration in progress
//   done, err         - sticky success / failure flags
//   err_code          - ERR_NONE / ERR_TIMEOUT / ERR_SPREAD
//   min_high,max_high - extremes of the last completed measurement
// Optional feature: define WS2812B_AUTOCAL_GLITCH_FILTER_EN to discard high
// pulses shorter than GLITCH_CYC cycles (they are invisible to the statistics
// and do not split the surrounding bit period).
module ws2812b_autocal_ctrl
    import ws2812b_autocal_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SAMPLE_BITS = 16,
    parameter int TIMEOUT_CYC = 8192,
    parameter int MIN_SPREAD  = 8,
    parameter int IDLE_MULT   = 48,
    parameter int DEF_THRESH  = 38,
    parameter int DEF_IDLE    = 3840
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             start,
    input  logic             abort,
    output logic [CNT_W-1:0] threshold_cycles,
    output logic [CNT_W-1:0] idle_ticks,
    output logic             cfg_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] min_high,
    output logic [CNT_W-1:0] max_high
);

`ifdef WS2812B_AUTOCAL_GLITCH_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    localparam int BC_W = $clog2(SAMPLE_BITS + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BC_W-1:0]  BC_ONE    = BC_W'(1);
    localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(SAMPLE_BITS);
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SPREAD_C  = CNT_W'(MIN_SPREAD);
    localparam logic [CNT_W-1:0] MULT_C    = CNT_W'(IDLE_MULT);
    localparam logic [CNT_W-1:0] GLITCH_C  = CNT_W'(GLITCH_CYC);
    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(DEF_THRESH);
    localparam logic [CNT_W-1:0] IDLE_C    = CNT_W'(DEF_IDLE);

    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] high_width;
    logic [CNT_W-1:0] period;

    ws2812b_edge_timer #(
        .CNT_W (CNT_W)
    ) u_edge_timer (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .rise       (rise),
        .fall       (fall),
        .high_width (high_width),
        .period     (period)
    );

    state_t           state_reg;
    logic [CNT_W-1:0] min_acc_reg;
    logic [CNT_W-1:0] max_acc_reg;
    logic [CNT_W-1:0] max_per_reg;
    // pend_per_reg: period ending at the current pulse's rise, only folded
    // into max_per_reg once the pulse proves not to be a glitch.
    // per_carry_reg: time already accumulated before a discarded spike.
    logic [CNT_W-1:0] pend_per_reg;
    logic [CNT_W-1:0] per_carry_reg;
    logic [BC_W-1:0]  bit_cnt_reg;
    logic [TO_W-1:0]  to_cnt_reg;

    logic [CNT_W-1:0]   spread;
    logic [CNT_W:0]     thr_sum;
    logic [CNT_W-1:0]   thr_val;
    logic [2*CNT_W-1:0] idl_prod;
    logic [CNT_W-1:0]   idl_val;
    logic [CNT_W:0]     carry_sum;
    logic [CNT_W-1:0]   pend_val;
    logic [BC_W-1:0]    bit_cnt_next;
    logic               glitch;
    logic               measuring;
    logic               timeout_hit;

    assign spread       = max_acc_reg - min_acc_reg;
    assign thr_sum      = {1'b0, min_acc_reg} + {1'b0, max_acc_reg};
    assign thr_val      = thr_sum[CNT_W:1];
    assign idl_prod     = {{CNT_W{1'b0}}, max_per_reg} * {{CNT_W{1'b0}}, MULT_C};
    assign idl_val      = (|idl_prod[2*CNT_W-1:CNT_W]) ? '1 : idl_prod[CNT_W-1:0];
    assign carry_sum    = {1'b0, per_carry_reg} + {1'b0, period};
    assign pend_val     = carry_sum[CNT_W] ? '1 : carry_sum[CNT_W-1:0];
    assign bit_cnt_next = bit_cnt_reg + BC_ONE;
    assign glitch       = FILTER_EN && (high_width < GLITCH_C);
    assign measuring    = (state_reg == WAIT_LOW) || (state_reg == WAIT_RISE) ||
                          (state_reg == MEAS_HIGH) || (state_reg == MEAS_LOW);
    assign timeout_hit  = measuring && !(rise || fall) && (to_cnt_reg == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            min_acc_reg      <= '1;
            max_acc_reg      <= '0;
            max_per_reg      <= '0;
            pend_per_reg     <= '0;
            per_carry_reg    <= '0;
            bit_cnt_reg      <= '0;
            to_cnt_reg       <= '0;
            threshold_cycles <= THRESH_C;
            idle_ticks       <= IDLE_C;
            cfg_valid        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            err_code         <= ERR_NONE;
            min_high         <= '0;
            max_high         <= '0;
        end else begin
            cfg_valid <= 1'b0;

            if ((state_reg == IDLE) || rise || fall) begin
                to_cnt_reg <= '0;
            end else if (to_cnt_reg != TO_LAST) begin
                to_cnt_reg <= to_cnt_reg + TO_ONE;
            end

            if ((state_reg != IDLE) && abort) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
            end else if (timeout_hit) begin
                err       <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state_reg <= IDLE;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start && !abort) begin
                            done          <= 1'b0;
                            err           <= 1'b0;
                            err_code      <= ERR_NONE;
                            min_acc_reg   <= '1;
                            max_acc_reg   <= '0;
                            max_per_reg   <= '0;
                            pend_per_reg  <= '0;
                            per_carry_reg <= '0;
                            bit_cnt_reg   <= '0;
                            state_reg     <= WAIT_LOW;
                            busy          <= 1'b1;
                        end
                    end
                    WAIT_LOW: begin
                        if (!din) begin
                            state_reg <= WAIT_RISE;
                        end
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            state_reg <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        if (fall) begin
                            if (glitch) begin
                                // Spike: keep the running period open across it.
                                if (bit_cnt_reg == '0) begin
                                    per_carry_reg <= '0;
                                    state_reg     <= WAIT_RISE;
                                end else begin
                                    per_carry_reg <= pend_per_reg;
                                    state_reg     <= MEAS_LOW;
                                end
                            end else begin
                                if (high_width < min_acc_reg) begin
                                    min_acc_reg <= high_width;
                                end
                                if (high_width > max_acc_reg) begin
                                    max_acc_reg <= high_width;
                                end
                                // The first pulse has no preceding rise to measure from.
                                if ((bit_cnt_reg != '0) && (pend_per_reg > max_per_reg)) begin
                                    max_per_reg <= pend_per_reg;
                                end
                                per_carry_reg <= '0;
                                bit_cnt_reg   <= bit_cnt_next;
                                state_reg     <= (bit_cnt_next == BC_LAST) ? COMPUTE : MEAS_LOW;
                            end
                        end
                    end
                    MEAS_LOW: begin
                        if (rise) begin
                            pend_per_reg <= pend_val;
                            state_reg    <= MEAS_HIGH;
                        end
                    end
                    COMPUTE: begin
                        min_high <= min_acc_reg;
                        max_high <= max_acc_reg;
                        if (spread < SPREAD_C) begin
                            err       <= 1'b1;
                            err_code  <= ERR_SPREAD;
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            // Registered here so the update is visible during COMMIT.
                            threshold_cycles <= thr_val;
                            idle_ticks       <= idl_val;
                            cfg_valid        <= 1'b1;
                            done             <= 1'b1;
                            state_reg        <= COMMIT;
                        end
                    end
                    COMMIT: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
